// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Shared definitions for the MOV/MOC memory handshake initiator.
//   Holds access-type codes, error codes, read/write polarity, the
//   controller state enum and a small alignment helper.
package mem_bus_pkg;

  // RAM typeData encoding
  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;
  localparam logic [1:0] TYPE_RSVD = 2'b11;

  // err_code values, meaningful only while err is high
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RSVD     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Same polarity as the RAM rw pin
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] acc_type,
                                         input logic [1:0] addr_lsb);
    return ((acc_type == TYPE_HALF) && addr_lsb[0]) ||
           ((acc_type == TYPE_WORD) && (addr_lsb != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   RAM side of the MOV/MOC four-phase handshake.
//   master : initiator (drives address/data/control and mem_mov)
//   slave  : RAM (returns mem_dout and mem_moc)
//   Signals:
//     mem_addr  byte address          mem_din   write data
//     mem_rw    1 = read, 0 = write   mem_type  byte/half/word
//     mem_mov   operation valid       mem_dout  read data
//     mem_moc   operation complete
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_rw;
  logic [1:0]        mem_type;
  logic              mem_mov;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_moc;

  modport master (
    output mem_addr,
    output mem_din,
    output mem_rw,
    output mem_type,
    output mem_mov,
    input  mem_dout,
    input  mem_moc
  );

  modport slave (
    input  mem_addr,
    input  mem_din,
    input  mem_rw,
    input  mem_type,
    input  mem_mov,
    output mem_dout,
    output mem_moc
  );

endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// load_extend
//   Combinational load formatter: takes the raw RAM word and returns the
//   byte/halfword/word value zero- or sign-extended to DATA_W.
//   Ports:
//     i_type    access type code
//     i_signed  1 = sign-extend, 0 = zero-extend
//     i_raw     raw RAM DataOut
//     o_data    extended load data
module load_extend
  import mem_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_type,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_raw,
  output logic [DATA_W-1:0] o_data
);

  logic w_fill_b;
  logic w_fill_h;

  assign w_fill_b = i_signed & i_raw[7];
  assign w_fill_h = i_signed & i_raw[15];

  // Upper lanes of the raw word are ignored for narrow loads.
  always_comb begin
    o_data = i_raw;
    case (i_type)
      TYPE_BYTE: o_data = {{(DATA_W-8){w_fill_b}}, i_raw[7:0]};
      TYPE_HALF: o_data = {{(DATA_W-16){w_fill_h}}, i_raw[15:0]};
      default:   o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Initiator side of the MOV/MOC memory handshake. Takes one load/store
//   command at a time, validates type and alignment, then runs a full
//   four-phase MOV/MOC transaction. Loads return extended data.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     req..req_wdata  command from the datapath (sampled only in IDLE)
//     busy            high from acceptance until back in IDLE
//     done / err      one-cycle completion / rejection-or-abort pulses
//     err_code        cause of err
//     rdata           extended load data, valid with done
//     mem             RAM handshake bus (master side)
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_IDLE    | no transaction, mem_mov low, accepts req
//   ST_ASSERT  | mem_mov high, waiting for mem_moc to rise
//   ST_RELEASE | mem_mov low, waiting for mem_moc to fall
module mem_access_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_rw,
  input  logic [1:0]        req_type,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] rdata,
  mem_access_ctrl_if.master mem
);

  // Counter value on the last allowed waiting cycle of a phase.
  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;

  logic              r_busy,      w_busy_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_err,       w_err_nxt;
  logic [1:0]        r_err_code,  w_err_code_nxt;
  logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
  logic [DATA_W-1:0] r_rd_raw,    w_rd_raw_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_addr_nxt;
  logic [DATA_W-1:0] r_mem_din,   w_din_nxt;
  logic              r_mem_rw,    w_rw_nxt;
  logic [1:0]        r_mem_type,  w_type_nxt;
  logic              r_mem_mov,   w_mov_nxt;
  logic              r_signed,    w_signed_nxt;

  logic              w_req_rsvd;
  logic              w_req_misal;
  logic              w_tc;
  logic [DATA_W-1:0] w_din_fmt;
  logic [DATA_W-1:0] w_ext;

  assign w_req_rsvd  = (req_type == TYPE_RSVD);
  assign w_req_misal = is_misaligned(req_type, req_addr[1:0]);
  assign w_tc        = (r_cnt == TC_VAL);

  // Store data is right-justified; unused upper lanes are driven to zero.
  always_comb begin
    w_din_fmt = req_wdata;
    case (req_type)
      TYPE_BYTE: w_din_fmt = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
      TYPE_HALF: w_din_fmt = {{(DATA_W-16){1'b0}}, req_wdata[15:0]};
      default:   w_din_fmt = req_wdata;
    endcase
  end

  // Extension uses the latched type/sign so it matches the captured word.
  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .i_type   (r_mem_type),
    .i_signed (r_signed),
    .i_raw    (r_rd_raw),
    .o_data   (w_ext)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_rdata    <= '0;
      r_rd_raw   <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_rw   <= RW_READ;
      r_mem_type <= TYPE_BYTE;
      r_mem_mov  <= 1'b0;
      r_signed   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rd_raw   <= w_rd_raw_nxt;
      r_mem_addr <= w_addr_nxt;
      r_mem_din  <= w_din_nxt;
      r_mem_rw   <= w_rw_nxt;
      r_mem_type <= w_type_nxt;
      r_mem_mov  <= w_mov_nxt;
      r_signed   <= w_signed_nxt;
    end
  end

  // Next-state logic. A MOC edge takes priority over a timeout that
  // expires in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req && !w_req_rsvd && !w_req_misal) begin
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (mem.mem_moc) begin
          w_state_nxt = ST_RELEASE;
        end else if (w_tc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!mem.mem_moc || w_tc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_mov_nxt      = (w_state_nxt == ST_ASSERT);
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = r_err_code;
    w_rdata_nxt    = r_rdata;
    w_rd_raw_nxt   = r_rd_raw;
    w_addr_nxt     = r_mem_addr;
    w_din_nxt      = r_mem_din;
    w_rw_nxt       = r_mem_rw;
    w_type_nxt     = r_mem_type;
    w_signed_nxt   = r_signed;
    // Cleared on every state entry, counts while waiting in a phase.
    w_cnt_nxt      = ((r_state == ST_IDLE) || (w_state_nxt != r_state)) ?
                     8'd0 : r_cnt + 8'd1;

    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (w_req_rsvd) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_RSVD;
          end else if (w_req_misal) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_MISALIGN;
          end else begin
            w_addr_nxt   = req_addr;
            w_din_nxt    = w_din_fmt;
            w_rw_nxt     = req_rw;
            w_type_nxt   = req_type;
            w_signed_nxt = req_signed;
          end
        end
      end
      ST_ASSERT: begin
        if (mem.mem_moc) begin
          if (r_mem_rw == RW_READ) begin
            w_rd_raw_nxt = mem.mem_dout;
          end
        end else if (w_tc) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      ST_RELEASE: begin
        if (!mem.mem_moc) begin
          w_done_nxt = 1'b1;
          // rdata only changes on a successful load.
          if (r_mem_rw == RW_READ) begin
            w_rdata_nxt = w_ext;
          end
        end else if (w_tc) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign err_code     = r_err_code;
  assign rdata        = r_rdata;
  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_din  = r_mem_din;
  assign mem.mem_rw   = r_mem_rw;
  assign mem.mem_type = r_mem_type;
  assign mem.mem_mov  = r_mem_mov;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_rw = 1'b1;
  logic [1:0]  req_type = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_mis = 0;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_rw     (req_rw),
    .req_type   (req_type),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .rdata      (rdata),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  // ---------------- RAM responder ----------------
  logic [7:0]  ram [0:255];
  logic        moc_q = 1'b0;
  int          rcnt = 0;
  bit          fast = 1'b1;
  bit          hang = 1'b0;
  int          a_dly = 1;
  int          r_dly = 1;
  logic [31:0] junk = 32'hA5C3_5A3C;
  logic [7:0]  ra;

  assign bus.mem_moc = hang ? 1'b0 : (fast ? bus.mem_mov : moc_q);

  always @(posedge clk) begin
    if (hang || fast) begin
      moc_q <= 1'b0;
      rcnt  <= 0;
    end else if (bus.mem_mov && !moc_q) begin
      if (rcnt == a_dly - 1) begin moc_q <= 1'b1; rcnt <= 0; end
      else rcnt <= rcnt + 1;
    end else if (!bus.mem_mov && moc_q) begin
      if (rcnt == r_dly - 1) begin moc_q <= 1'b0; rcnt <= 0; end
      else rcnt <= rcnt + 1;
    end else begin
      rcnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 5);
    end else if (bus.mem_mov && bus.mem_moc && bus.mem_rw == 1'b0) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_din[7:0];
      if (bus.mem_type != 2'b00) ram[bus.mem_addr[7:0] + 8'd1] <= bus.mem_din[15:8];
      if (bus.mem_type == 2'b10) begin
        ram[bus.mem_addr[7:0] + 8'd2] <= bus.mem_din[23:16];
        ram[bus.mem_addr[7:0] + 8'd3] <= bus.mem_din[31:24];
      end
    end
  end

  // Narrow reads carry junk in the unused lanes.
  always_comb begin
    ra = bus.mem_addr[7:0];
    case (bus.mem_type)
      2'b00:   bus.mem_dout = {junk[31:8], ram[ra]};
      2'b01:   bus.mem_dout = {junk[31:16], ram[ra + 8'd1], ram[ra]};
      default: bus.mem_dout = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
    endcase
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:255];
  logic [31:0] exp_addr, exp_din, exp_rdata;
  logic        exp_rw;
  logic [1:0]  exp_type;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
    exp_addr = '0; exp_din = '0; exp_rdata = '0; exp_rw = 1'b1; exp_type = 2'b00;
  endtask

  function automatic logic [31:0] model_load(input int nb, input bit sg, input logic [31:0] addr);
    longint v;
    v = 0;
    for (int i = nb - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[8'(addr + 32'(i))]);
    if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_busy"},     32'(busy), 32'd0);
    check({pfx, "_done"},     32'(done), 32'd0);
    check({pfx, "_err"},      32'(err), 32'd0);
    check({pfx, "_err_code"}, 32'(err_code), 32'd0);
    check({pfx, "_rdata"},    rdata, 32'd0);
    check({pfx, "_mov"},      32'(bus.mem_mov), 32'd0);
    check({pfx, "_rw"},       32'(bus.mem_rw), 32'd1);
    check({pfx, "_type"},     32'(bus.mem_type), 32'd0);
    check({pfx, "_addr"},     bus.mem_addr, 32'd0);
    check({pfx, "_din"},      bus.mem_din, 32'd0);
  endtask

  // mode: 0 = combinational responder, 1 = delayed (ad/rd cycles), 2 = no MOC
  task automatic run_txn(input logic rw, input logic [1:0] t, input bit sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int mode, input int ad, input int rd, input bit poke);
    int nb, exp_end, exp_mov, j_end, mov_hi;
    bit rej, seen_done, seen_err, stable_bad, busy_bad, excl_bad, post_bad;
    logic [1:0] ecode, got_code;
    nb = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    rej = 1'b0; ecode = 2'b00;
    if (t == 2'd3) begin rej = 1'b1; ecode = 2'b10; end
    else if (addr % nb != 0) begin rej = 1'b1; ecode = 2'b01; end
    if (mode == 2) ecode = 2'b11;
    if (!rej) begin
      exp_addr = addr; exp_rw = rw; exp_type = t;
      exp_din  = (nb == 4) ? wd : wd & ((32'd1 << (8 * nb)) - 32'd1);
    end
    exp_end = rej ? 0 : (mode == 2) ? TMO : (mode == 0) ? 2 : ad + rd + 2;
    exp_mov = rej ? 0 : (mode == 2) ? TMO : (mode == 0) ? 1 : ad + 1;
    fast = (mode == 0); hang = (mode == 2); a_dly = ad; r_dly = rd; junk = $urandom;

    @(negedge clk);
    req = 1'b1; req_rw = rw; req_type = t; req_signed = sg; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req = 1'b0; req_type = 2'($urandom_range(0, 3)); req_addr = $urandom; req_wdata = $urandom;

    j_end = -1; mov_hi = 0; seen_done = 0; seen_err = 0; got_code = 2'b00;
    stable_bad = 0; busy_bad = 0; excl_bad = 0; post_bad = 0;
    for (int j = 0; j < 60; j++) begin
      if (j > 0) @(negedge clk);
      if (poke && j == 2) begin
        req = 1'b1; req_rw = 1'b0; req_type = 2'b10; req_addr = 32'h80; req_wdata = 32'h1111_2222;
      end
      if (poke && j == 3) req = 1'b0;
      if (done && err) excl_bad = 1;
      if (bus.mem_mov) mov_hi++;
      if (bus.mem_addr !== exp_addr || bus.mem_rw !== exp_rw ||
          bus.mem_type !== exp_type || bus.mem_din !== exp_din) stable_bad = 1;
      if (done || err) begin
        j_end = j; seen_done = done; seen_err = err; got_code = err_code;
        if (busy !== 1'b0) busy_bad = 1;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1;
    end

    check("end_cycle",  32'(j_end), 32'(exp_end));
    check("done",       32'(seen_done), 32'(!rej && mode != 2));
    check("err",        32'(seen_err), 32'(rej || mode == 2));
    if (rej || mode == 2) check("err_code", 32'(got_code), 32'(ecode));
    check("mov_cycles", 32'(mov_hi), 32'(exp_mov));
    check("mem_stable", 32'(stable_bad), 32'd0);
    check("busy",       32'(busy_bad), 32'd0);
    check("done_err_excl", 32'(excl_bad), 32'd0);

    if (!rej && mode != 2) begin
      if (rw == 1'b0) begin
        for (int i = 0; i < nb; i++) ref_mem[8'(addr + 32'(i))] = 8'(wd >> (8 * i));
      end else begin
        exp_rdata = model_load(nb, sg, addr);
      end
    end
    check("rdata", rdata, exp_rdata);

    @(negedge clk);
    check("pulse_width", 32'({done, err}), 32'd0);
    if (poke) begin
      for (int k = 0; k < 3; k++) begin
        if (k > 0) @(negedge clk);
        if (bus.mem_mov !== 1'b0 || busy !== 1'b0 || bus.mem_addr !== exp_addr) post_bad = 1;
      end
      check("busy_req_ignored", 32'(post_bad), 32'd0);
    end
    hang = 1'b0;
  endtask

  initial begin
    logic [1:0]  t;
    logic [31:0] addr;
    model_reset();

    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // Word write / read
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0, 0, 0);
    check("word_read_const", rdata, 32'hDEADBEEF);

    // Byte / half extension
    run_txn(1'b0, 2'b00, 1'b0, 32'h21, 32'h1234_5680, 0, 0, 0, 0);
    run_txn(1'b1, 2'b00, 1'b1, 32'h21, 32'h0, 0, 0, 0, 0);
    check("byte_signed_const", rdata, 32'hFFFFFF80);
    run_txn(1'b1, 2'b00, 1'b0, 32'h21, 32'h0, 0, 0, 0, 0);
    check("byte_unsigned_const", rdata, 32'h00000080);
    run_txn(1'b0, 2'b01, 1'b0, 32'h22, 32'hCAFE_8001, 0, 0, 0, 0);
    run_txn(1'b1, 2'b01, 1'b1, 32'h22, 32'h0, 0, 0, 0, 0);
    check("half_signed_const", rdata, 32'hFFFF8001);

    // Rejections
    run_txn(1'b1, 2'b10, 1'b0, 32'h13, 32'h0, 0, 0, 0, 0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h23, 32'h55, 0, 0, 0, 0);
    run_txn(1'b1, 2'b11, 1'b0, 32'h20, 32'h0, 0, 0, 0, 0);

    // Slow responder, then timeout with an ignored request while busy
    run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1, 5, 3, 0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h44, 32'h0BAD_F00D, 2, 0, 0, 1);

    // Reset while in ASSERT
    fast = 1'b0; hang = 1'b1;
    @(negedge clk);
    req = 1'b1; req_rw = 1'b1; req_type = 2'b10; req_addr = 32'h40;
    @(negedge clk);
    req = 1'b0;
    check("rst_pre_mov", 32'(bus.mem_mov), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    hang = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'({done, err, bus.mem_mov}), 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      t = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_txn(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)), addr, $urandom,
              int'($urandom_range(0, 1)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
